hit_resolver: RTL and testbench
===============================

# hit_resolver

Combat arbiter between the two player cores. Every clock it samples both players' attack, block and position signals, decides who landed a hit, and returns a one-cycle `hit` pulse plus an `opp_attack` warning to each player core. It also owns both health counters, applies full or chip damage, and declares the KO that ends a round.

## Interface
Parameters:
- POS_W, 10, width of the horizontal position inputs.
- ATTACK_RANGE, 40, maximum distance |p1_x − p2_x| at which an attack connects.
- DAMAGE, 10, health removed by an unblocked hit.
- BLOCK_DAMAGE, 2, chip damage removed by a blocked hit.
- HEALTH_MAX, 100, starting health; must be ≤ 255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- round_start  in  1  one-cycle pulse that starts or restarts a round.
- p1_attack_active  in  1  player 1 is in an attack state.
- p1_block_active  in  1  player 1 is blocking.
- p1_x  in  POS_W  player 1 position, unsigned.
- p2_attack_active  in  1  player 2 is in an attack state.
- p2_block_active  in  1  player 2 is blocking.
- p2_x  in  POS_W  player 2 position, unsigned.
- p1_hit  out  1  one-cycle pulse: player 1 took an unblocked hit (drives p1 core hit input).
- p2_hit  out  1  one-cycle pulse: player 2 took an unblocked hit.
- p1_opp_attack  out  1  player 2 is attacking within range (drives p1 core opponent-attack input).
- p2_opp_attack  out  1  player 1 is attacking within range.
- p1_health  out  8  player 1 health.
- p2_health  out  8  player 2 health.
- ko  out  1  round over.
- winner  out  2  01 = p1 won, 10 = p2 won, 11 = draw, 00 = no result.

## Operation
- States: WAIT, FIGHT, KO. Reset enters WAIT.
- Reset values:
  - health = HEALTH_MAX for both players.
  - hit, opp_attack, ko, winner all 0.
  - armed flags and previous-attack registers 0.
- round_start has priority over everything, in any state. It loads both healths with HEALTH_MAX, clears armed, ko and winner, and enters FIGHT.
- Distance: dist = |p1_x − p2_x|, computed unsigned in POS_W bits without wraparound (subtract the smaller from the larger).
- in_range = (dist ≤ ATTACK_RANGE).
- Attack edges, per player:
  - prev_attack holds last cycle's attack_active and updates in every state.
  - rise = attack_active & ~prev_attack.
  - armed sets on rise while in FIGHT.
  - armed clears when attack_active is low, when the attack scores, or on round_start.
- Scoring (FIGHT only): score_A = A_attack_active & (armed_A | rise_A) & in_range. Each attack scores at most once. An attack started out of range still scores if the distance closes while the attack is held.
- Effect of a score by A on defender D:
  - If D_block_active: D_health −= BLOCK_DAMAGE, and D_hit is not pulsed.
  - Otherwise: D_health −= DAMAGE, and D_hit pulses.
- Subtraction saturates at 0: if health ≤ damage, health becomes 0.
- Simultaneous scores (trade): both apply in the same cycle.
- opp_attack, registered, FIGHT only: p1_opp_attack ← p2_attack_active & in_range; p2_opp_attack is symmetric. Both are 0 in WAIT and KO.
- FIGHT → KO when either post-update health is 0.
  - winner = 01 if only p2 is 0, 10 if only p1 is 0, 11 if both are 0.
  - ko = 1.
- KO: no scoring, health frozen, ko and winner held until round_start or reset.
- WAIT: no scoring, health held at HEALTH_MAX.

## Timing
- Single clock; every output is registered.
- Hit latency: an attack that qualifies in cycle N produces the hit pulse, the health update and (if lethal) ko and winner in cycle N+1.
- hit pulse width is exactly 1 cycle per scoring attack, regardless of how long attack_active is held.
- opp_attack lags its inputs by 1 cycle. It drops 1 cycle after attack_active falls or in_range goes false.
- round_start in cycle N: health = HEALTH_MAX and state FIGHT in N+1. A score that also qualifies in cycle N is discarded.
- Reset mid-round: outputs take their reset values immediately (asynchronous), and the block stays in WAIT until round_start.
- Re-attack: attack_active must go low for at least one cycle before the same player can score again.

## Test plan
- Reset, then round_start: p1_health = p2_health = 100, ko = 0, winner = 00, state FIGHT.
- p1_x = 100, p2_x = 130, p1 attack held 5 cycles with p2 not blocking → p2_hit high for exactly 1 cycle (cycle after attack rise), p2_health = 90, no further decrement.
- Same stimulus with p2_block_active = 1 → p2_hit stays 0, p2_health = 98.
- p1 attack starts at dist = 60, p2 walks to dist = 30 while the attack is held → one hit on the cycle after range is reached. At dist = 41 → no hit, p2_opp_attack = 0.
- Both players attack in the same cycle at dist = 10, both health = 10 → p1_hit = p2_hit = 1, both health = 0, ko = 1, winner = 11; further attacks leave all outputs frozen.
- ko asserted, round_start pulsed in the same cycle as a new qualifying attack → health = 100/100, ko = 0, no hit pulse; reset asserted mid-round → all outputs at reset values immediately.

Source files
------------

// File: rtl/hit_resolver.sv
// Combat arbiter between two player cores: resolves attacks into hit pulses,
// owns both health counters and declares the KO that ends a round.
module hit_resolver #(
    parameter int POS_W        = 10,
    parameter int ATTACK_RANGE = 40,
    parameter int DAMAGE       = 10,
    parameter int BLOCK_DAMAGE = 2,
    parameter int HEALTH_MAX   = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             round_start,
    input  logic             p1_attack_active,
    input  logic             p1_block_active,
    input  logic [POS_W-1:0] p1_x,
    input  logic             p2_attack_active,
    input  logic             p2_block_active,
    input  logic [POS_W-1:0] p2_x,
    output logic             p1_hit,
    output logic             p2_hit,
    output logic             p1_opp_attack,
    output logic             p2_opp_attack,
    output logic [7:0]       p1_health,
    output logic [7:0]       p2_health,
    output logic             ko,
    output logic [1:0]       winner
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FIGHT = 2'd1,
        S_KO    = 2'd2
    } state_t;

    localparam logic [7:0]  L_HMAX  = 8'(HEALTH_MAX);
    localparam logic [7:0]  L_DMG   = 8'(DAMAGE);
    localparam logic [7:0]  L_CHIP  = 8'(BLOCK_DAMAGE);
    localparam logic [31:0] L_RANGE = 32'(ATTACK_RANGE);

    state_t r_state;
    state_t w_stateNext;

    logic r_p1Prev;
    logic r_p2Prev;
    logic r_p1Armed;
    logic r_p2Armed;

    logic [POS_W-1:0] w_dist;
    logic             w_inRange;
    logic             w_fight;
    logic             w_p1Rise;
    logic             w_p2Rise;
    logic             w_p1Score;
    logic             w_p2Score;

    logic       w_p1ArmedNext;
    logic       w_p2ArmedNext;
    logic       w_p1HitNext;
    logic       w_p2HitNext;
    logic       w_p1OppNext;
    logic       w_p2OppNext;
    logic [7:0] w_p1HealthNext;
    logic [7:0] w_p2HealthNext;
    logic       w_koNext;
    logic [1:0] w_winnerNext;

    function automatic logic [7:0] satSub(input logic [7:0] health, input logic [7:0] dmg);
        return (health <= dmg) ? 8'd0 : (health - dmg);
    endfunction

    // Subtract the smaller position from the larger so the distance never wraps.
    assign w_dist    = (p1_x >= p2_x) ? (p1_x - p2_x) : (p2_x - p1_x);
    assign w_inRange = ({{(32-POS_W){1'b0}}, w_dist} <= L_RANGE);

    assign w_fight  = (r_state == S_FIGHT);
    assign w_p1Rise = p1_attack_active & ~r_p1Prev;
    assign w_p2Rise = p2_attack_active & ~r_p2Prev;

    // A score is discarded when round_start arrives in the same cycle.
    assign w_p1Score = w_fight & ~round_start & p1_attack_active & (r_p1Armed | w_p1Rise) & w_inRange;
    assign w_p2Score = w_fight & ~round_start & p2_attack_active & (r_p2Armed | w_p2Rise) & w_inRange;

    always_comb begin
        w_p1ArmedNext = r_p1Armed;
        w_p2ArmedNext = r_p2Armed;

        if (!p1_attack_active || w_p1Score) begin
            w_p1ArmedNext = 1'b0;
        end else if (w_p1Rise && w_fight) begin
            w_p1ArmedNext = 1'b1;
        end

        if (!p2_attack_active || w_p2Score) begin
            w_p2ArmedNext = 1'b0;
        end else if (w_p2Rise && w_fight) begin
            w_p2ArmedNext = 1'b1;
        end

        if (round_start) begin
            w_p1ArmedNext = 1'b0;
            w_p2ArmedNext = 1'b0;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_p1HealthNext = p1_health;
        w_p2HealthNext = p2_health;
        w_p1HitNext    = 1'b0;
        w_p2HitNext    = 1'b0;
        w_p1OppNext    = 1'b0;
        w_p2OppNext    = 1'b0;
        w_koNext       = ko;
        w_winnerNext   = winner;

        case (r_state)
            S_WAIT: begin
                w_p1HealthNext = L_HMAX;
                w_p2HealthNext = L_HMAX;
            end
            S_FIGHT: begin
                w_p1OppNext = p2_attack_active & w_inRange;
                w_p2OppNext = p1_attack_active & w_inRange;

                if (w_p2Score) begin
                    w_p1HealthNext = satSub(p1_health, p1_block_active ? L_CHIP : L_DMG);
                    w_p1HitNext    = ~p1_block_active;
                end
                if (w_p1Score) begin
                    w_p2HealthNext = satSub(p2_health, p2_block_active ? L_CHIP : L_DMG);
                    w_p2HitNext    = ~p2_block_active;
                end

                if ((w_p1HealthNext == 8'd0) || (w_p2HealthNext == 8'd0)) begin
                    w_stateNext  = S_KO;
                    w_koNext     = 1'b1;
                    w_winnerNext = {w_p1HealthNext == 8'd0, w_p2HealthNext == 8'd0};
                end
            end
            S_KO: begin
            end
            default: begin
                w_stateNext = S_WAIT;
            end
        endcase

        if (round_start) begin
            w_stateNext    = S_FIGHT;
            w_p1HealthNext = L_HMAX;
            w_p2HealthNext = L_HMAX;
            w_p1HitNext    = 1'b0;
            w_p2HitNext    = 1'b0;
            w_koNext       = 1'b0;
            w_winnerNext   = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_WAIT;
            r_p1Prev      <= 1'b0;
            r_p2Prev      <= 1'b0;
            r_p1Armed     <= 1'b0;
            r_p2Armed     <= 1'b0;
            p1_hit        <= 1'b0;
            p2_hit        <= 1'b0;
            p1_opp_attack <= 1'b0;
            p2_opp_attack <= 1'b0;
            p1_health     <= L_HMAX;
            p2_health     <= L_HMAX;
            ko            <= 1'b0;
            winner        <= 2'b00;
        end else begin
            r_state       <= w_stateNext;
            r_p1Prev      <= p1_attack_active;
            r_p2Prev      <= p2_attack_active;
            r_p1Armed     <= w_p1ArmedNext;
            r_p2Armed     <= w_p2ArmedNext;
            p1_hit        <= w_p1HitNext;
            p2_hit        <= w_p2HitNext;
            p1_opp_attack <= w_p1OppNext;
            p2_opp_attack <= w_p2OppNext;
            p1_health     <= w_p1HealthNext;
            p2_health     <= w_p2HealthNext;
            ko            <= w_koNext;
            winner        <= w_winnerNext;
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: each task drives one scenario and checks
// hand-computed health, hit, opponent-attack and KO values.
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       round_start;
    logic       p1_attack_active;
    logic       p1_block_active;
    logic [9:0] p1_x;
    logic       p2_attack_active;
    logic       p2_block_active;
    logic [9:0] p2_x;
    logic       p1_hit;
    logic       p2_hit;
    logic       p1_opp_attack;
    logic       p2_opp_attack;
    logic [7:0] p1_health;
    logic [7:0] p2_health;
    logic       ko;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    hit_resolver dut (
        .clk              (clk),
        .reset            (reset),
        .round_start      (round_start),
        .p1_attack_active (p1_attack_active),
        .p1_block_active  (p1_block_active),
        .p1_x             (p1_x),
        .p2_attack_active (p2_attack_active),
        .p2_block_active  (p2_block_active),
        .p2_x             (p2_x),
        .p1_hit           (p1_hit),
        .p2_hit           (p2_hit),
        .p1_opp_attack    (p1_opp_attack),
        .p2_opp_attack    (p2_opp_attack),
        .p1_health        (p1_health),
        .p2_health        (p2_health),
        .ko               (ko),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs are sampled on the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic startRound();
        p1_attack_active = 1'b0;
        p2_attack_active = 1'b0;
        p1_block_active  = 1'b0;
        p2_block_active  = 1'b0;
        round_start      = 1'b1;
        step();
        round_start      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; round_start = 1'b0;
        p1_attack_active = 1'b0; p1_block_active = 1'b0; p1_x = 10'd100;
        p2_attack_active = 1'b0; p2_block_active = 1'b0; p2_x = 10'd110;
        step(); step();
        total++; if (p1_health !== 8'd100) begin bad++; $display("[TB] FAIL reset_p1_health got=%0d want=100", p1_health); end
        total++; if (p2_health !== 8'd100) begin bad++; $display("[TB] FAIL reset_p2_health got=%0d want=100", p2_health); end
        total++; if ({p1_hit, p2_hit, p1_opp_attack, p2_opp_attack, ko, winner} !== 7'd0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000000", {p1_hit, p2_hit, p1_opp_attack, p2_opp_attack, ko, winner}); end
        reset = 1'b0;
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_opp_attack} !== 2'b00) begin bad++; $display("[TB] FAIL wait_no_score got=%b want=00", {p2_hit, p2_opp_attack}); end
        total++; if (p2_health !== 8'd100) begin bad++; $display("[TB] FAIL wait_health got=%0d want=100", p2_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_round_start();
        startRound();
        total++; if ({p1_health, p2_health} !== {8'd100, 8'd100}) begin bad++; $display("[TB] FAIL start_health got=%0d/%0d want=100/100", p1_health, p2_health); end
        total++; if ({ko, winner} !== 3'b000) begin bad++; $display("[TB] FAIL start_ko got=%b want=000", {ko, winner}); end
    endtask

    task automatic test_unblocked_hit();
        int hits;
        startRound();
        p1_x = 10'd100; p2_x = 10'd130;
        p1_attack_active = 1'b1;
        step();
        total++; if (p2_hit !== 1'b1) begin bad++; $display("[TB] FAIL hit_first_cycle got=%b want=1", p2_hit); end
        total++; if (p2_opp_attack !== 1'b1) begin bad++; $display("[TB] FAIL hit_opp got=%b want=1", p2_opp_attack); end
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            hits += int'(p2_hit);
        end
        total++; if (hits !== 0) begin bad++; $display("[TB] FAIL hit_held_extra got=%0d want=0", hits); end
        total++; if (p2_health !== 8'd90) begin bad++; $display("[TB] FAIL hit_health got=%0d want=90", p2_health); end
        total++; if (p1_hit !== 1'b0) begin bad++; $display("[TB] FAIL hit_p1_clean got=%b want=0", p1_hit); end
        p1_attack_active = 1'b0;
        step();
        total++; if (p2_opp_attack !== 1'b0) begin bad++; $display("[TB] FAIL opp_drop got=%b want=0", p2_opp_attack); end
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_health} !== {1'b1, 8'd80}) begin bad++; $display("[TB] FAIL reattack got=%b/%0d want=1/80", p2_hit, p2_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_blocked_hit();
        int hits;
        startRound();
        p1_x = 10'd100; p2_x = 10'd130;
        p2_block_active  = 1'b1;
        p1_attack_active = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            hits += int'(p2_hit);
        end
        total++; if (hits !== 0) begin bad++; $display("[TB] FAIL block_hit_pulse got=%0d want=0", hits); end
        total++; if (p2_health !== 8'd98) begin bad++; $display("[TB] FAIL block_health got=%0d want=98", p2_health); end
        p1_attack_active = 1'b0; p2_block_active = 1'b0;
        step();
    endtask

    task automatic test_range_closing();
        startRound();
        p1_x = 10'd100; p2_x = 10'd160;
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_opp_attack} !== 2'b00) begin bad++; $display("[TB] FAIL range60 got=%b want=00", {p2_hit, p2_opp_attack}); end
        p2_x = 10'd141;
        step();
        total++; if ({p2_hit, p2_opp_attack, p2_health} !== {2'b00, 8'd100}) begin bad++; $display("[TB] FAIL range41 got=%b/%b/%0d want=0/0/100", p2_hit, p2_opp_attack, p2_health); end
        p2_x = 10'd130;
        step();
        total++; if ({p2_hit, p2_opp_attack, p2_health} !== {2'b11, 8'd90}) begin bad++; $display("[TB] FAIL range_close got=%b/%b/%0d want=1/1/90", p2_hit, p2_opp_attack, p2_health); end
        step();
        total++; if ({p2_hit, p2_health} !== {1'b0, 8'd90}) begin bad++; $display("[TB] FAIL range_once got=%b/%0d want=0/90", p2_hit, p2_health); end
        p1_attack_active = 1'b0;
        step();
        p2_x = 10'd140;
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_health} !== {1'b1, 8'd80}) begin bad++; $display("[TB] FAIL range40 got=%b/%0d want=1/80", p2_hit, p2_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_reverse_positions();
        startRound();
        p1_x = 10'd300; p2_x = 10'd270;
        p2_attack_active = 1'b1;
        step();
        total++; if ({p1_hit, p1_opp_attack, p2_hit, p1_health} !== {3'b110, 8'd90}) begin bad++; $display("[TB] FAIL reverse got=%b/%b/%b/%0d want=1/1/0/90", p1_hit, p1_opp_attack, p2_hit, p1_health); end
        p2_attack_active = 1'b0;
        step();
        p1_x = 10'd0; p2_x = 10'd1000;
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_opp_attack, p2_health} !== {2'b00, 8'd100}) begin bad++; $display("[TB] FAIL far_apart got=%b/%b/%0d want=0/0/100", p2_hit, p2_opp_attack, p2_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_saturation_winner();
        startRound();
        p1_x = 10'd100; p2_x = 10'd120;
        p2_block_active  = 1'b1;
        p1_attack_active = 1'b1;
        step();
        p1_attack_active = 1'b0; p2_block_active = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            p1_attack_active = 1'b1; step();
            p1_attack_active = 1'b0; step();
        end
        total++; if ({p2_health, ko} !== {8'd8, 1'b0}) begin bad++; $display("[TB] FAIL sat_pre got=%0d/%b want=8/0", p2_health, ko); end
        p1_attack_active = 1'b1;
        step();
        total++; if (p2_health !== 8'd0) begin bad++; $display("[TB] FAIL sat_zero got=%0d want=0", p2_health); end
        total++; if ({ko, winner, p2_hit, p1_health} !== {4'b1011, 8'd100}) begin bad++; $display("[TB] FAIL p1_wins got=%b/%b/%b/%0d want=1/01/1/100", ko, winner, p2_hit, p1_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_trade_ko();
        int trades;
        startRound();
        p1_x = 10'd200; p2_x = 10'd210;
        trades = 0;
        for (int i = 0; i < 9; i++) begin
            p1_attack_active = 1'b1; p2_attack_active = 1'b1;
            step();
            trades += int'(p1_hit & p2_hit);
            p1_attack_active = 1'b0; p2_attack_active = 1'b0;
            step();
        end
        total++; if (trades !== 9) begin bad++; $display("[TB] FAIL trade_count got=%0d want=9", trades); end
        total++; if ({p1_health, p2_health, ko} !== {8'd10, 8'd10, 1'b0}) begin bad++; $display("[TB] FAIL trade_pre got=%0d/%0d/%b want=10/10/0", p1_health, p2_health, ko); end
        p1_attack_active = 1'b1; p2_attack_active = 1'b1;
        step();
        total++; if ({p1_hit, p2_hit, p1_health, p2_health} !== {2'b11, 16'd0}) begin bad++; $display("[TB] FAIL trade_final got=%b%b/%0d/%0d want=11/0/0", p1_hit, p2_hit, p1_health, p2_health); end
        total++; if ({ko, winner} !== 3'b111) begin bad++; $display("[TB] FAIL draw got=%b/%b want=1/11", ko, winner); end
        p1_attack_active = 1'b0; p2_attack_active = 1'b0;
        step();
        p1_attack_active = 1'b1; p2_attack_active = 1'b1;
        step(); step();
        total++; if ({p1_hit, p2_hit, p1_opp_attack, p2_opp_attack} !== 4'b0000) begin bad++; $display("[TB] FAIL ko_frozen_flags got=%b want=0000", {p1_hit, p2_hit, p1_opp_attack, p2_opp_attack}); end
        total++; if ({p1_health, p2_health, ko, winner} !== {16'd0, 3'b111}) begin bad++; $display("[TB] FAIL ko_frozen_state got=%0d/%0d/%b/%b want=0/0/1/11", p1_health, p2_health, ko, winner); end
        p1_attack_active = 1'b0; p2_attack_active = 1'b0;
        step();
    endtask

    task automatic test_restart_priority();
        p1_x = 10'd100; p2_x = 10'd120;
        round_start      = 1'b1;
        p1_attack_active = 1'b1;
        step();
        round_start = 1'b0;
        total++; if ({p1_health, p2_health} !== {8'd100, 8'd100}) begin bad++; $display("[TB] FAIL restart_health got=%0d/%0d want=100/100", p1_health, p2_health); end
        total++; if ({ko, winner, p2_hit} !== 4'b0000) begin bad++; $display("[TB] FAIL restart_flags got=%b want=0000", {ko, winner, p2_hit}); end
        step();
        total++; if ({p2_hit, p2_health} !== {1'b0, 8'd100}) begin bad++; $display("[TB] FAIL restart_discard got=%b/%0d want=0/100", p2_hit, p2_health); end
        p1_attack_active = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        startRound();
        p1_x = 10'd100; p2_x = 10'd130;
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_health} !== {1'b1, 8'd90}) begin bad++; $display("[TB] FAIL pre_reset got=%b/%0d want=1/90", p2_hit, p2_health); end
        #2 reset = 1'b1;
        #1;
        total++; if ({p2_hit, p2_opp_attack, p2_health} !== {2'b00, 8'd100}) begin bad++; $display("[TB] FAIL async_reset got=%b/%b/%0d want=0/0/100", p2_hit, p2_opp_attack, p2_health); end
        @(negedge clk);
        reset = 1'b0;
        p1_attack_active = 1'b0;
        step();
        p1_attack_active = 1'b1;
        step();
        total++; if ({p2_hit, p2_health, ko} !== {1'b0, 8'd100, 1'b0}) begin bad++; $display("[TB] FAIL stays_wait got=%b/%0d/%b want=0/100/0", p2_hit, p2_health, ko); end
        p1_attack_active = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_start();
        test_unblocked_hit();
        test_blocked_hit();
        test_range_closing();
        test_reverse_positions();
        test_saturation_winner();
        test_trade_ko();
        test_restart_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
